// File: rtl/posit_sched_pkg.sv
// Shared types and constants for the posit converter scheduler.
package posit_sched_pkg;

    localparam int unsigned TAG_W = 2;

    localparam logic [63:0] DBL_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DBL_QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        ZERO = 2'd1,
        NAR  = 2'd2
    } pclass_e;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        pclass_e          cls;
    } tpipe_t;

    // Posit special values: all-zero is ZERO, sign bit alone is NaR.
    function automatic pclass_e classify(input logic [63:0] p, input int unsigned n);
        pclass_e c;
        c = NORM;
        if (p == 64'd0) begin
            c = ZERO;
        end else if (p == (64'd1 << (n - 1))) begin
            c = NAR;
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arb_n #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_c,
    output logic [IW-1:0]   idx_c,
    output logic            any_c
);

    always_comb begin
        logic [IW-1:0] j;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        j       = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            j = IW'((32'(ptr_i) + off) % NREQ);
            if (!any_c && req_i[j]) begin
                any_c      = 1'b1;
                grant_c[j] = 1'b1;
                idx_c      = j;
            end
        end
    end

endmodule

// File: rtl/posit_conv_sched.sv
// Round-robin scheduler sharing one fixed-latency posit->double converter, with a credit-protected result FIFO.
// Define POSIT_CONV_SPECIAL_EN to force ZERO/NaR posits to +0.0 / quiet NaN on retire.
module posit_conv_sched
    import posit_sched_pkg::*;
#(
    parameter int unsigned N     = 36,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned TW    = TAG_W,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      cv_in,
    output logic              cv_start,
    input  logic [63:0]       cv_out,
    input  logic              cv_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic [TW-1:0]     out_tag,
    output logic              err
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(DEPTH + LAT + 3);
    localparam int unsigned GW = $clog2(LAT + 1);
    localparam int unsigned FW = TAG_W + 64;

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   cv_in_q;
    tpipe_t         iss_q, iss_d;
    tpipe_t         pipe_q [LAT];
    logic [FW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d, rd_prev;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  guard_q;
    logic           err_q;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            gany, issue_ok, issue, push, pop, guard_on;
    logic [SW-1:0]   inflight;
    logic [N-1:0]    sel_data;
    logic [63:0]     res;
    tpipe_t          tail;

    rr_arb_n #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_c (gnt),
        .idx_c   (gidx),
        .any_c   (gany)
    );

    // Credit: everything issued and not yet popped; a head popped this cycle frees its slot.
    always_comb begin
        inflight = SW'(iss_q.v);
        for (int unsigned k = 0; k < LAT; k++) begin
            inflight = inflight + SW'(pipe_q[k].v);
        end
        pop      = (cnt_q != '0) && out_ready;
        issue_ok = (SW'(cnt_q) + inflight) < (SW'(DEPTH) + SW'(pop));
        issue    = gany && issue_ok;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx == IW'(i)) begin
                sel_data = req_data[i*N +: N];
            end
        end
    end

    always_comb begin
        iss_d     = '0;
        iss_d.v   = issue;
        iss_d.tag = TAG_W'(gidx);
`ifdef POSIT_CONV_SPECIAL_EN
        iss_d.cls = classify(64'(sel_data), N);
`else
        iss_d.cls = NORM;
`endif
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
        end
    end

    // Retire: the tail of the tag pipe lines up with the converter's done strobe.
    always_comb begin
        tail     = pipe_q[LAT-1];
        guard_on = (guard_q != '0);
        push     = !guard_on && tail.v && cv_done;
        res      = cv_out;
`ifdef POSIT_CONV_SPECIAL_EN
        if (tail.cls == ZERO) begin
            res = DBL_ZERO;
        end else if (tail.cls == NAR) begin
            res = DBL_QNAN;
        end
`endif
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        if (pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        rd_prev = (rd_q == '0) ? PW'(DEPTH - 1) : rd_q - PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cv_in_q <= '0;
            iss_q   <= '0;
            for (int unsigned k = 0; k < LAT; k++) pipe_q[k] <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            guard_q <= GW'(LAT);
            err_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (issue) cv_in_q <= sel_data;
            iss_q     <= iss_d;
            pipe_q[0] <= iss_q;
            for (int unsigned k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
            if (push) mem_q[wr_q] <= {tail.tag, res};
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (guard_on) guard_q <= guard_q - GW'(1);
            if (!guard_on && (tail.v != cv_done)) err_q <= 1'b1;
        end
    end

    // Empty FIFO shows the most recently popped entry, so outputs hold.
    assign req_ready = issue_ok ? gnt : '0;
    assign cv_in     = cv_in_q;
    assign cv_start  = iss_q.v;
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? mem_q[rd_q][63:0] : mem_q[rd_prev][63:0];
    assign out_tag   = TW'(out_valid ? mem_q[rd_q][FW-1:64] : mem_q[rd_prev][FW-1:64]);
    assign err       = err_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> (cnt_q < CW'(DEPTH)));

endmodule

// File: tb/tb_posit_conv_sched.sv
// Directed bench for posit_conv_sched with a transaction-level model and a bench-side converter.
module tb_posit_conv_sched;

    localparam int NREQ = 4;
    localparam int N    = 36;
    localparam int LAT  = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      cv_in;
    logic              cv_start;
    logic [63:0]       cv_out;
    logic              cv_done;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [1:0]        out_tag;
    logic              err;
    logic              stray;

    posit_conv_sched dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cv_in(cv_in), .cv_start(cv_start), .cv_out(cv_out),
        .cv_done(cv_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in converter: fixed latency, not reset, recognisable result pattern.
    function automatic logic [63:0] conv(input logic [35:0] p);
        return {28'h0C0FFEE, p};
    endfunction

    function automatic logic [63:0] model_res(input logic [35:0] p);
`ifdef POSIT_CONV_SPECIAL_EN
        if (p == 36'h0) return 64'h0;
        if (p == 36'h8_0000_0000) return 64'h7FF8_0000_0000_0000;
`endif
        return conv(p);
    endfunction

    logic [LAT-1:0] dpipe = '0;
    logic [63:0]    opipe [LAT];
    initial for (int k = 0; k < LAT; k++) opipe[k] = '0;
    always @(posedge clk) begin
        dpipe    <= {dpipe[LAT-2:0], cv_start};
        opipe[0] <= conv(cv_in);
        for (int k = 1; k < LAT; k++) opipe[k] <= opipe[k-1];
    end
    assign cv_done = dpipe[LAT-1] | stray;
    assign cv_out  = opipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state and observation logs.
    typedef struct { logic [1:0] tag; logic [63:0] data; int rdy; } exp_t;
    typedef struct { int cyc; logic [1:0] tag; logic [63:0] data; } pop_t;
    exp_t        exp_q[$];
    pop_t        pop_log[$];
    int          acc_log[$];
    int          start_log[$];
    int          mptr = 0;
    logic        m_start = 0;
    logic [35:0] m_cvin = '0;
    logic        m_err = 0;
    logic [63:0] m_last_data = '0;
    logic [1:0]  m_last_tag = '0;
    int          since = 0;

    always @(negedge clk) begin : cmp
        logic    ev, pop, ok, found;
        int      gi, j;
        exp_t    h;
        pop_t    pl;
        logic [35:0] d;
        if (!rst_n) begin
            chk("rst req_ready", 64'(req_ready), 64'h0);
            chk("rst cv_start", 64'(cv_start), 64'h0);
            chk("rst cv_in", 64'(cv_in), 64'h0);
            chk("rst out_valid", 64'(out_valid), 64'h0);
            chk("rst out_data", out_data, 64'h0);
            chk("rst out_tag", 64'(out_tag), 64'h0);
            chk("rst err", 64'(err), 64'h0);
            exp_q.delete();
            mptr = 0; m_start = 0; m_err = 0; m_last_data = '0; m_last_tag = '0; since = 0;
        end else begin
            cyc++;
            ev  = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            pop = ev && out_ready;
            ok  = (exp_q.size() - (pop ? 1 : 0)) < DEPTH;
            found = 0; gi = 0;
            if (ok) begin
                for (int off = 0; off < NREQ; off++) begin
                    j = (mptr + off) % NREQ;
                    if (!found && req_valid[j]) begin
                        found = 1; gi = j;
                    end
                end
            end
            chk("req_ready", 64'(req_ready), found ? (64'd1 << gi) : 64'd0);
            chk("cv_start", 64'(cv_start), 64'(m_start));
            if (m_start) chk("cv_in", 64'(cv_in), 64'(m_cvin));
            chk("out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
            end else begin
                chk("out_data hold", out_data, m_last_data);
                chk("out_tag hold", 64'(out_tag), 64'(m_last_tag));
            end
            chk("err", 64'(err), 64'(m_err));
            if ((req_valid & req_ready) != '0) acc_log.push_back(cyc);
            if (cv_start) start_log.push_back(cyc);
            if (out_valid && out_ready) begin
                pl.cyc = cyc; pl.tag = out_tag; pl.data = out_data;
                pop_log.push_back(pl);
            end
            if (pop) begin
                h = exp_q.pop_front();
                m_last_data = h.data; m_last_tag = h.tag;
            end
            m_start = found;
            if (found) begin
                d = req_data[gi*N +: N];
                m_cvin = d;
                h.tag = 2'(gi); h.data = model_res(d); h.rdy = cyc + 2 + LAT;
                exp_q.push_back(h);
                mptr = (gi + 1) % NREQ;
            end
            if (stray && since >= LAT) m_err = 1;
            since++;
        end
    end

    // Per-requester source queues.
    logic [35:0] src_mem [NREQ][16];
    int          src_rd [NREQ];
    int          src_wr [NREQ];

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (src_rd[i] != src_wr[i]);
            req_data[i*N +: N] = src_mem[i][src_rd[i] % 16];
        end
    endtask

    task automatic push_src(input int i, input logic [35:0] d);
        src_mem[i][src_wr[i] % 16] = d;
        src_wr[i]++;
        drive();
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i]) src_rd[i]++;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        pop_log.delete(); acc_log.delete(); start_log.delete();
    endtask

    function automatic int acc_at(input int k);
        return (k < acc_log.size()) ? acc_log[k] : -1000;
    endfunction
    function automatic int start_at(input int k);
        return (k < start_log.size()) ? start_log[k] : -1000;
    endfunction
    function automatic int pcyc_at(input int k);
        return (k < pop_log.size()) ? pop_log[k].cyc : -1000;
    endfunction
    function automatic logic [63:0] ptag_at(input int k);
        return (k < pop_log.size()) ? 64'(pop_log[k].tag) : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction
    function automatic logic [63:0] pdata_at(input int k);
        return (k < pop_log.size()) ? pop_log[k].data : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t2 [8];
        int t3 [4];
        t2 = '{1, 2, 3, 0, 1, 2, 3, 0};
        t3 = '{1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0; src_wr[i] = 0;
            for (int k = 0; k < 16; k++) src_mem[i][k] = '0;
        end
        rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0; stray = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(3);

        // Single request: latency and data.
        clear_logs();
        out_ready = 1'b1;
        push_src(0, 36'h4_0000_0000);
        run(10);
        chk("t1 start latency", 64'(start_at(0) - acc_at(0)), 64'd1);
        chk("t1 out latency", 64'(pcyc_at(0) - acc_at(0)), 64'd4);
        chk("t1 tag", ptag_at(0), 64'd0);
        chk("t1 data", pdata_at(0), 64'h0C0F_FEE4_0000_0000);

        // All requesters busy: one grant per cycle in rotation.
        clear_logs();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) push_src(i, 36'(36'h1_0000_0000 * (i + 1) + k));
        run(20);
        for (int k = 0; k < 8; k++) chk("t2 tag order", ptag_at(k), 64'(t2[k]));
        for (int k = 0; k < 7; k++) chk("t2 back-to-back", 64'(acc_at(k + 1) - acc_at(k)), 64'd1);

        // Stalled consumer: credit caps issues at DEPTH, then drains in order.
        clear_logs();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NREQ; i++) push_src(i, 36'(36'h0_0100_0000 * (i + 1) + 36'(k * 16)));
        run(12);
        chk("t3 issues while stalled", 64'(acc_log.size()), 64'd4);
        chk("t3 req_ready closed", 64'(req_ready), 64'd0);
        out_ready = 1'b1;
        run(30);
        chk("t3 drained count", 64'(pop_log.size()), 64'd12);
        for (int k = 0; k < 4; k++) chk("t3 drain order", ptag_at(k), 64'(t3[k]));

        // Push and pop in the same cycle with two entries held.
        clear_logs();
        out_ready = 1'b0;
        push_src(0, 36'h0_0000_0011);
        push_src(0, 36'h0_0000_0022);
        run(8);
        push_src(0, 36'h1_2345_6789);
        run(3);
        out_ready = 1'b1;
        run(10);
        chk("t4 pops", 64'(pop_log.size()), 64'd3);
        chk("t4 pop cycles", 64'(pcyc_at(2) - pcyc_at(0)), 64'd2);
        chk("t4 empty valid", 64'(out_valid), 64'd0);
        chk("t4 hold data", out_data, 64'h0C0F_FEE1_2345_6789);

        // Reset with work in flight; stale done from the converter must be ignored.
        push_src(1, 36'h0_0000_0AAA);
        push_src(1, 36'h0_0000_0BBB);
        run(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(6);
        chk("t5 err after reset", 64'(err), 64'd0);
        chk("t5 out_valid after reset", 64'(out_valid), 64'd0);

        // Special posit values, then a stray done strobe.
        clear_logs();
        push_src(2, 36'h0_0000_0000);
        push_src(3, 36'h8_0000_0000);
        run(10);
        chk("t6 tag zero", ptag_at(0), 64'd2);
        chk("t6 tag nar", ptag_at(1), 64'd3);
`ifdef POSIT_CONV_SPECIAL_EN
        chk("t6 zero data", pdata_at(0), 64'h0000_0000_0000_0000);
        chk("t6 nar data", pdata_at(1), 64'h7FF8_0000_0000_0000);
`else
        chk("t6 zero data", pdata_at(0), 64'h0C0F_FEE0_0000_0000);
        chk("t6 nar data", pdata_at(1), 64'h0C0F_FEE8_0000_0000);
`endif
        chk("t6 err before stray", 64'(err), 64'd0);
        stray = 1'b1;
        step();
        stray = 1'b0;
        run(2);
        chk("t6 err sticky", 64'(err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
